arithmetic_micro_operation: RTL and testbench



---
 rtl/arith_pkg.sv | 19 +
 rtl/b_input_logic.sv | 22 ++
 rtl/arithmetic_micro_operation.sv | 46 ++++
 tb/tb_arithmetic_micro_operation.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared widths, select encoding and sign-extension helper for the arithmetic unit.
package arith_pkg;

  localparam int unsigned OPW  = 4;
  localparam int unsigned RESW = 5;

  typedef enum logic [1:0] {
    SEL_ADD  = 2'b00,
    SEL_SUBB = 2'b01,
    SEL_INC  = 2'b10,
    SEL_DEC  = 2'b11
  } sel_e;

  // Widen a two's complement operand to the result width.
  function automatic logic [RESW-1:0] sext(input logic [OPW-1:0] v);
    return {{(RESW - OPW){v[OPW-1]}}, v};
  endfunction

endpackage

// File: rtl/b_input_logic.sv
// B-input selector: chooses the adder's second operand from the select code.
module b_input_logic
  import arith_pkg::*;
(
  input  logic [1:0]      s,
  input  logic [RESW-1:0] b_ext,
  output logic [RESW-1:0] y_c
);

  // Pass, invert, or force the B operand to all-zeros / all-ones.
  always_comb begin
    y_c = b_ext;
    case (sel_e'(s))
      SEL_ADD:  y_c = b_ext;
      SEL_SUBB: y_c = ~b_ext;
      SEL_INC:  y_c = '0;
      SEL_DEC:  y_c = '1;
      default:  y_c = b_ext;
    endcase
  end

endmodule

// File: rtl/arithmetic_micro_operation.sv
// Registered 4-bit signed arithmetic micro-operation unit (adder + B-input selector).
module arithmetic_micro_operation
  import arith_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic [1:0]      s,
  input  logic [OPW-1:0]  a,
  input  logic [OPW-1:0]  b,
  input  logic            carry,
  output logic [RESW-1:0] data
);

  logic [RESW-1:0] a_ext;
  logic [RESW-1:0] b_ext;
  logic [RESW-1:0] y;
  logic [RESW-1:0] data_d;
  logic [RESW-1:0] data_q;

  assign a_ext = sext(a);
  assign b_ext = sext(b);

  b_input_logic u_b_input_logic (
    .s     (s),
    .b_ext (b_ext),
    .y_c   (y)
  );

  // 5-bit adder; the carry-in both completes subtraction and selects the paired op.
  always_comb begin
    data_d = '0;
    data_d = a_ext + y + RESW'(carry);
  end

  // Result register with synchronous active-low clear.
  always_ff @(posedge clock) begin
    if (!reset) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data = data_q;

endmodule

// File: tb/tb_arithmetic_micro_operation.sv
// Self-checking bench for arithmetic_micro_operation: directed cases plus randomized sweep.
module tb_arithmetic_micro_operation;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] s;
  logic [3:0] a;
  logic [3:0] b;
  logic       carry;
  logic [4:0] data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  arithmetic_micro_operation dut (
    .clock (clock),
    .reset (reset),
    .s     (s),
    .a     (a),
    .b     (b),
    .carry (carry),
    .data  (data)
  );

  // Reference: the eight operations written as plain signed integer arithmetic.
  function automatic logic [4:0] ref_op(input logic [1:0] fs, input logic fc,
                                        input logic [3:0] fa, input logic [3:0] fb);
    int ia;
    int ib;
    int r;
    ia = int'($signed(fa));
    ib = int'($signed(fb));
    case ({fs, fc})
      3'b000:  r = ia + ib;
      3'b001:  r = ia + ib + 1;
      3'b010:  r = ia - ib - 1;
      3'b011:  r = ia - ib;
      3'b100:  r = ia;
      3'b101:  r = ia + 1;
      3'b110:  r = ia - 1;
      default: r = ia;
    endcase
    return 5'(r);
  endfunction

  task automatic check(input string tag, input logic [4:0] exp);
    n_tests++;
    assert (data === exp) else begin
      n_fail++;
      $error("FAIL %s: data=%0d (0x%h) expected=%0d (0x%h)",
             tag, $signed(data), data, $signed(exp), exp);
    end
  endtask

  task automatic drive(input logic [1:0] ts, input logic tc,
                       input logic [3:0] ta, input logic [3:0] tb);
    s     = ts;
    carry = tc;
    a     = ta;
    b     = tb;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic directed(input string tag, input logic [1:0] ts, input logic tc,
                          input logic [3:0] ta, input logic [3:0] tb,
                          input logic [4:0] exp);
    drive(ts, tc, ta, tb);
    step();
    check(tag, exp);
  endtask

  initial begin
    logic [1:0] rs;
    logic       rc;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [4:0] held;

    // Reset held for two edges, then released.
    reset = 1'b0;
    drive(2'b00, 1'b0, 4'd5, 4'd3);
    step();
    check("reset_edge1", 5'd0);
    step();
    check("reset_edge2", 5'd0);
    reset = 1'b1;
    step();
    check("reset_release", 5'd8);

    // Directed boundary cases.
    directed("add_min",      2'b00, 1'b0, 4'(-8), 4'(-8), 5'(-16));
    directed("add_inc_max",  2'b00, 1'b1, 4'd7,   4'd7,   5'd15);
    directed("sub_max",      2'b01, 1'b1, 4'd7,   4'(-8), 5'd15);
    directed("sub_dec_min",  2'b01, 1'b0, 4'(-8), 4'd7,   5'(-16));
    directed("sub_neg",      2'b01, 1'b1, 4'd3,   4'd5,   5'(-2));
    directed("transfer",     2'b10, 1'b0, 4'(-3), 4'd0,   5'(-3));
    directed("increment",    2'b10, 1'b1, 4'(-3), 4'd0,   5'(-2));
    directed("transfer_b6",  2'b11, 1'b1, 4'(-3), 4'd6,   5'(-3));
    directed("dec_min",      2'b11, 1'b0, 4'(-8), 4'd0,   5'(-9));
    directed("dec_zero",     2'b11, 1'b0, 4'd0,   4'd0,   5'(-1));

    // Mid-stream reset clears regardless of inputs.
    reset = 1'b0;
    drive(2'b00, 1'b1, 4'd7, 4'd7);
    step();
    check("reset_midstream", 5'd0);
    reset = 1'b1;
    step();
    check("reset_midstream_release", 5'd15);

    // Randomized sweep: every {s,carry} code, inputs held for two edges,
    // then perturbed mid-cycle to confirm the output only moves on an edge.
    for (int i = 0; i < 64; i++) begin
      rs = 2'(i % 8 >> 1);
      rc = 1'(i % 2);
      ra = 4'($urandom);
      rb = 4'($urandom);
      drive(rs, rc, ra, rb);
      step();
      check("sweep_edge1", ref_op(rs, rc, ra, rb));
      step();
      check("sweep_edge2", ref_op(rs, rc, ra, rb));
      held = ref_op(rs, rc, ra, rb);
      #3;
      drive(2'($urandom), 1'($urandom), 4'($urandom), 4'($urandom));
      #3;
      check("sweep_midcycle_hold", held);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
